// File: rtl/johnson_pkg.sv
// Johnson (twisted-ring) code helpers shared by the digit cell and the counter top.
// Codes live in a fixed-width container; the active width w is passed per call.
package johnson_pkg;

   localparam int JC_MAX_W = 16;
   typedef logic [JC_MAX_W-1:0] jc_t;

   function automatic int cw_of(input int radix);
      return $clog2(radix);
   endfunction

   function automatic jc_t jc_up(input jc_t q, input int w);
      jc_t  r;
      logic msb;
      r   = '0;
      msb = 1'b0;
      for (int i = 0; i < JC_MAX_W; i++) begin
         if (i == w - 1) msb = q[i];
      end
      for (int i = 1; i < JC_MAX_W; i++) begin
         if (i < w) r[i] = q[i-1];
      end
      r[0] = ~msb;
      return r;
   endfunction

   function automatic jc_t jc_down(input jc_t q, input int w);
      jc_t r;
      r = '0;
      for (int i = 0; i < JC_MAX_W - 1; i++) begin
         if (i < w - 1) r[i] = q[i+1];
      end
      for (int i = 0; i < JC_MAX_W; i++) begin
         if (i == w - 1) r[i] = ~q[0];
      end
      return r;
   endfunction

   // Upper half of the ring has the MSB set; its index counts down with the ones.
   function automatic jc_t jc_decode(input jc_t q, input int w);
      int   pc;
      logic msb;
      pc  = 0;
      msb = 1'b0;
      for (int i = 0; i < JC_MAX_W; i++) begin
         if (i < w) pc = pc + int'(q[i]);
         if (i == w - 1) msb = q[i];
      end
      return jc_t'(msb ? 2 * w - pc : pc);
   endfunction

   function automatic jc_t jc_encode(input jc_t v, input int w);
      jc_t r;
      int  n;
      r = '0;
      n = int'(v);
      for (int i = 0; i < JC_MAX_W; i++) begin
         if (i < w) r[i] = (n < w) ? (i < n) : (i >= n - w);
      end
      return r;
   endfunction

   function automatic logic jc_is_zero(input jc_t q, input int w);
      return (q & jc_t'((1 << w) - 1)) == '0;
   endfunction

   function automatic logic jc_is_max(input jc_t q, input int w);
      return (q & jc_t'((1 << w) - 1)) == jc_encode(jc_t'(2 * w - 1), w);
   endfunction

endpackage

// File: rtl/johnson_digit.sv
// One Johnson-coded digit: holds the ring code and its registered binary index.
// Stepping, clearing and loading are decided here; the enable chain lives above.
module johnson_digit
   import johnson_pkg::*;
#(
   parameter  int RADIX = 10,
   localparam int W     = RADIX / 2,
   localparam int CW    = cw_of(RADIX)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          step,
   input  logic          up,
   input  logic          clr,
   input  logic          load,
   input  logic [CW-1:0] load_idx,
   output logic [W-1:0]  q,
   output logic [CW-1:0] idx,
   output logic          at_max,
   output logic          at_zero
);

   localparam logic [CW:0] RADIX_V = (CW + 1)'(RADIX);

   jc_t q_ext;
   jc_t q_nxt;
   jc_t idx_nxt;

   assign q_ext   = jc_t'(q);
   assign at_max  = jc_is_max(q_ext, W);
   assign at_zero = jc_is_zero(q_ext, W);

   always_comb begin
      q_nxt = q_ext;
      if (clr) begin
         q_nxt = '0;
      end else if (load) begin
         q_nxt = ({1'b0, load_idx} < RADIX_V) ? jc_encode(jc_t'(load_idx), W) : '0;
      end else if (step) begin
         q_nxt = up ? jc_up(q_ext, W) : jc_down(q_ext, W);
      end
      idx_nxt = jc_decode(q_nxt, W);
   end

   // Index is decoded from the next code so it never lags the ring by a cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         q   <= '0;
         idx <= '0;
      end else begin
         q   <= q_nxt[W-1:0];
         idx <= idx_nxt[CW-1:0];
      end
   end

endmodule

// File: rtl/johnson_decade_counter.sv
// Multi-digit Johnson counter: ripple enable chain, wrap/saturate, carry pulse
// and sticky out-of-range load flag around a row of johnson_digit cells.
module johnson_decade_counter
   import johnson_pkg::*;
#(
   parameter  int DIGITS   = 2,
   parameter  int RADIX    = 10,
   parameter  int SATURATE = 0,
   localparam int W        = RADIX / 2,
   localparam int CW       = cw_of(RADIX)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 up,
   input  logic                 clr,
   input  logic                 load,
   input  logic [DIGITS*CW-1:0] load_val,
   output logic [DIGITS*W-1:0]  q,
   output logic [DIGITS*CW-1:0] val,
   output logic                 carry,
   output logic                 err
);

   localparam logic        SAT     = (SATURATE != 0);
   localparam logic [CW:0] RADIX_V = (CW + 1)'(RADIX);

   logic [DIGITS:0]   chain;
   logic [DIGITS-1:0] at_max;
   logic [DIGITS-1:0] at_zero;
   logic [DIGITS-1:0] bad;
   logic              full;
   logic              hold;

   // chain[i] = digit i steps; chain[DIGITS] = the whole counter passes an end.
   assign chain[0] = en;
   assign full     = chain[DIGITS];
   assign hold     = SAT & full;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      assign chain[g+1] = chain[g] & (up ? at_max[g] : at_zero[g]);
      assign bad[g]     = ({1'b0, load_val[g*CW +: CW]} >= RADIX_V);

      johnson_digit #(.RADIX(RADIX)) u_digit (
         .clk      (clk),
         .rst      (rst),
         .step     (chain[g] & ~hold),
         .up       (up),
         .clr      (clr),
         .load     (load),
         .load_idx (load_val[g*CW +: CW]),
         .q        (q[g*W +: W]),
         .idx      (val[g*CW +: CW]),
         .at_max   (at_max[g]),
         .at_zero  (at_zero[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         carry <= 1'b0;
         err   <= 1'b0;
      end else begin
         carry <= ~load & full;
         if (load && (|bad)) err <= 1'b1;
      end
   end

endmodule
